// File: rtl/cmd_encod_linear_rd_pkg.sv
// Shared types, constants and sequencer word encoders for the linear DDR3 read encoder.
package cmd_encod_linear_rd_pkg;

  localparam int CMD_PAUSE_BITS = 10;
  localparam int CMD_DONE_BIT   = 10;

  // RAS/CAS/WE codes, positive logic
  typedef enum logic [2:0] {
    CMD_NOP       = 3'd0,
    CMD_READ      = 3'd2,
    CMD_ACTIVATE  = 3'd4,
    CMD_PRECHARGE = 3'd5
  } rcw_e;

  typedef enum logic [2:0] {
    ADDR_ACT, ADDR_TRCD, ADDR_READ, ADDR_RTP, ADDR_PRE, ADDR_TRP, ADDR_DONE, ADDR_IDLE
  } rom_addr_e;

  typedef struct packed {
    logic                      pre_done;
    logic [CMD_PAUSE_BITS-1:0] pause;
    logic                      sel;
    logic                      nop;
    logic                      buf_wr;
    logic                      buf_rst;
    rcw_e                      cmd;
  } rom_word_t;

  function automatic logic [31:0] func_encode_cmd(
    input logic [14:0] addr, input logic [2:0] bank, input logic [2:0] rcw,
    input logic odt_en, input logic cke, input logic sel, input logic dq_en,
    input logic dqs_en, input logic dqs_toggle, input logic dci, input logic buf_wr,
    input logic buf_rd, input logic nop, input logic buf_rst);
    return {addr, bank, rcw, odt_en, cke, sel, dq_en, dqs_en, dqs_toggle, dci,
            buf_wr, buf_rd, nop, buf_rst};
  endfunction

  // NOP word: the address field carries the pause length and the done flag
  function automatic logic [31:0] func_encode_skip(
    input logic [CMD_PAUSE_BITS-1:0] skip, input logic done, input logic [2:0] bank,
    input logic odt_en, input logic cke, input logic dq_en, input logic dqs_en,
    input logic dqs_toggle, input logic dci, input logic buf_wr, input logic buf_rd,
    input logic buf_rst);
    logic [14:0] f;
    f = '0;
    f[CMD_PAUSE_BITS-1:0] = skip;
    f[CMD_DONE_BIT]       = done;
    return {f, bank, 3'b000, odt_en, cke, 1'b0, dq_en, dqs_en, dqs_toggle, dci,
            buf_wr, buf_rd, 1'b0, buf_rst};
  endfunction

endpackage

// File: rtl/cmd_encod_linear_rd_if.sv
// Request / encoded-command bundle between a requester and the linear read encoder.
interface cmd_encod_linear_rd_if #(
  parameter int ADDRESS_NUMBER = 15,
  parameter int COLADDR_NUMBER = 10,
  parameter int NUM_XFER_BITS  = 6
);
  logic [2:0]                bank_in;
  logic [ADDRESS_NUMBER-1:0] row_in;
  logic [COLADDR_NUMBER-4:0] start_col;
  logic [NUM_XFER_BITS-1:0]  num128_in;
  logic                      skip_next_page_in;
  logic                      start;
  logic [31:0]               enc_cmd;
  logic                      enc_wr;
  logic                      enc_done;

  modport master (
    output bank_in, row_in, start_col, num128_in, skip_next_page_in, start,
    input  enc_cmd, enc_wr, enc_done
  );

  modport slave (
    input  bank_in, row_in, start_col, num128_in, skip_next_page_in, start,
    output enc_cmd, enc_wr, enc_done
  );
endinterface

// File: rtl/cmd_encod_linear_rd.sv
// DDR3 linear read sequence encoder: ACTIVATE, up to 64 back-to-back READs, PRECHARGE.
module cmd_encod_linear_rd
  import cmd_encod_linear_rd_pkg::*;
#(
  parameter int   ADDRESS_NUMBER = 15,
  parameter int   COLADDR_NUMBER = 10,
  parameter int   NUM_XFER_BITS  = 6,
  parameter logic RSEL           = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  cmd_encod_linear_rd_if.slave bus
);

  localparam int COL_W = COLADDR_NUMBER - 3;
  localparam int REM_W = NUM_XFER_BITS + 1;

  logic                      r_gen_run;
  rom_addr_e                 r_gen_addr;
  rom_word_t                 r_rom, w_rom;
  logic [REM_W-1:0]          r_remaining;
  logic [2:0]                r_bank;
  logic [ADDRESS_NUMBER-1:0] r_row;
  logic [COL_W-1:0]          r_col;
  logic                      r_skip;
  logic [31:0]               r_enc_cmd, w_enc_cmd;
  logic                      r_enc_wr, r_enc_done;
  logic                      w_start_new, w_pre_done, w_hold;
  logic [14:0]               w_addr;

  assign w_start_new = bus.start & ~r_gen_run;
  assign w_pre_done  = r_rom.pre_done & r_gen_run;
  assign w_hold      = (r_gen_addr == ADDR_READ) && (r_remaining > REM_W'(1));

  always_comb begin
    w_rom = '0;
    case (r_gen_addr)
      ADDR_ACT:  w_rom.cmd = CMD_ACTIVATE;
      ADDR_TRCD: w_rom.pause = CMD_PAUSE_BITS'(2);
      ADDR_READ: begin
        w_rom.cmd    = CMD_READ;
        w_rom.sel    = RSEL;
        w_rom.nop    = 1'b1;
        w_rom.buf_wr = 1'b1;
      end
      ADDR_RTP:  w_rom.pause = CMD_PAUSE_BITS'(2);
      ADDR_PRE: begin
        w_rom.cmd     = CMD_PRECHARGE;
        w_rom.buf_rst = 1'b1;
      end
      ADDR_TRP:  w_rom.pause = CMD_PAUSE_BITS'(2);
      ADDR_DONE: w_rom.pre_done = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gen_run   <= 1'b0;
      r_gen_addr  <= ADDR_ACT;
      r_rom       <= '0;
      r_remaining <= '0;
      r_bank      <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_skip      <= 1'b0;
    end else begin
      if (w_start_new)     r_gen_run <= 1'b1;
      else if (w_pre_done) r_gen_run <= 1'b0;

      if (!(bus.start || r_gen_run)) r_gen_addr <= ADDR_ACT;
      else if (!w_hold)              r_gen_addr <= rom_addr_e'(r_gen_addr + 3'd1);

      r_rom <= w_rom;

      // 0 requested bursts means a full page: MSB of remaining set
      if (w_start_new) begin
        r_bank      <= bus.bank_in;
        r_row       <= bus.row_in;
        r_col       <= bus.start_col;
        r_skip      <= bus.skip_next_page_in;
        r_remaining <= {bus.num128_in == '0, bus.num128_in};
      end else begin
        if (r_gen_run && w_hold)                 r_remaining <= r_remaining - REM_W'(1);
        if (r_gen_run && r_rom.cmd == CMD_READ)  r_col       <= r_col + COL_W'(1);
      end
    end
  end

  always_comb begin
    w_addr = '0;
    if (r_rom.cmd == CMD_READ) w_addr[COLADDR_NUMBER-1:3] = r_col;
    else                       w_addr[ADDRESS_NUMBER-1:0] = r_row;
    if (r_rom.cmd == CMD_NOP)
      w_enc_cmd = func_encode_skip(r_rom.pause, r_rom.pre_done, r_bank, 1'b0, 1'b0, 1'b0,
                                   1'b0, 1'b0, 1'b1, r_rom.buf_wr, 1'b0,
                                   r_rom.buf_rst & ~r_skip);
    else
      w_enc_cmd = func_encode_cmd(w_addr, r_bank, r_rom.cmd, 1'b0, 1'b0, r_rom.sel, 1'b0,
                                  1'b0, 1'b0, 1'b1, r_rom.buf_wr, 1'b0, r_rom.nop,
                                  r_rom.buf_rst & ~r_skip);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_enc_cmd  <= '0;
      r_enc_wr   <= 1'b0;
      r_enc_done <= 1'b0;
    end else begin
      r_enc_wr   <= r_gen_run;
      r_enc_done <= r_enc_wr & ~r_gen_run;
      if (r_gen_run) r_enc_cmd <= w_enc_cmd;
    end
  end

  assign bus.enc_cmd  = r_enc_cmd;
  assign bus.enc_wr   = r_enc_wr;
  assign bus.enc_done = r_enc_done;

endmodule
